c499_key_loader: RTL and testbench
==================================

# c499_key_loader

Serial key-load unit that sits directly upstream of the mux4-locked c499 SEC core and drives its 24 key inputs p1..p24. It accepts a framed, parity-protected serial key stream over a valid/ready handshake. It checks frame length and parity, then commits the key to a held parallel register. Once committed, the key is locked against further loads until an explicit relock.

## Interface
- KEY_W, 24, number of key bits; key_out[i] drives p(i+1).
- CNT_W, 5, beat-counter width; must satisfy 2^CNT_W > KEY_W+1.

- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- key_valid  in  1  source presents a beat on key_bit.
- key_bit  in  1  serial data: KEY_W key bits first, then 1 parity bit.
- key_last  in  1  marks the final beat, which is the parity beat; sampled only on accepted beats.
- key_ready  out  1  loader can accept a beat.
- relock  in  1  clears the committed key and re-arms the loader.
- key_out  out  KEY_W  committed key, connected to p1..p24 of the locked core.
- key_locked  out  1  key_out holds a valid committed key.
- commit_ok  out  1  one-cycle pulse when a key is committed.
- commit_err  out  1  one-cycle pulse when a frame is rejected.

## Operation
- Beat accepted when key_valid && key_ready on a rising edge.
- Beat k (k = 0..KEY_W-1) shifts into shadow bit k, LSB first. The first beat maps to p1.
- Beat KEY_W is the parity beat. Even parity is required: XOR of all KEY_W key bits and the parity bit must equal 0.
- FSM states:
  - IDLE: key_ready=1. The first accepted beat goes to SHIFT, with beat count=1.
  - SHIFT: key_ready=1. Accepted beats increment the count. The FSM goes to CHECK when key_last=1 is accepted, or when beat KEY_W (the 25th beat) is accepted regardless of key_last.
  - CHECK: key_ready=0, one cycle. Pass requires all of: count==KEY_W+1, key_last=1 on that beat, and parity even. On pass go to LOCKED; otherwise go to ERROR.
  - LOCKED: key_ready=0; key_out is loaded from shadow on the CHECK→LOCKED edge. key_locked=1. commit_ok=1 for the first LOCKED cycle only. Stream input is ignored.
  - ERROR: key_ready=0; commit_err=1 for exactly this one cycle, then IDLE. Shadow and count are cleared. key_out and key_locked are unchanged.
- A key_last accepted early (count < KEY_W+1) terminates the frame and produces an error.
- relock=1 in any state: next state IDLE, key_out=0, key_locked=0, shadow=0, count=0, no pulse. relock has priority over all other events in the same cycle.
- Counter never wraps; its maximum reachable value is KEY_W+1.

## Timing
- Reset values: key_out=0, key_locked=0, key_ready=1 (IDLE), commit_ok=0, commit_err=0. All internal state cleared.
- Reset asserted mid-frame aborts the frame immediately. No pulse is emitted.
- key_ready is a registered function of state only; it has no combinational path from key_valid.
- Latency from acceptance of the final beat at edge t:
  - CHECK during cycle t..t+1.
  - On pass: key_out, key_locked and commit_ok are valid after edge t+1.
  - On fail: commit_err is high after edge t+1 for one cycle, and key_ready returns to 1 after edge t+2.
- Minimum frame period with continuous valid: KEY_W+1 beats, plus CHECK, plus one ERROR cycle on rejection.
- All outputs are registered.
- key_out is stable while key_locked=1. The downstream core samples it combinationally.

## Test plan
- Good frame: key 0xA5C3F0 LSB first, parity 0, key_last on beat 25, continuous valid → key_ready low from cycle 26. commit_ok pulses once. key_out=0xA5C3F0 and key_locked=1 thereafter.
- Bad parity: key 0xA5C3F0 with parity 1 → commit_err pulses once; key_out stays 0, key_locked stays 0, key_ready=1 two cycles after the last beat. Then a correct frame commits.
- Length errors: key_last on beat 10 → commit_err after beat 10. No key_last on beat 25 → commit_err. key_out is unchanged in both cases.
- Locked ignore: after committing 0xA5C3F0, drive a 25-beat frame for 0x000001 → key_ready=0 throughout, key_out remains 0xA5C3F0, no pulses.
- Relock: relock asserted while locked → key_out=0 and key_locked=0 on the next cycle. Then load 0x123456 (parity 1) → commit_ok and key_out=0x123456. Also assert relock on the same cycle as CHECK → IDLE with no pulse.
- Async reset mid-frame: assert rst_n=0 after beat 12 between clock edges → outputs go to reset values immediately. After release, a full good frame commits normally.

Source files
------------

// File: rtl/c499_key_loader_if.sv
// Serial key-stream handshake between a key source and the c499 key loader.
interface c499_key_loader_if;
    logic key_valid;
    logic key_bit;
    logic key_last;
    logic key_ready;

    modport master (
        output key_valid,
        output key_bit,
        output key_last,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_bit,
        input  key_last,
        output key_ready
    );
endinterface

// File: rtl/c499_key_loader.sv
// Serial key loader for the mux4-locked c499 core.
// Collects an LSB-first key frame followed by an even-parity beat, validates
// length, framing and parity, then holds the key on key_out until a relock.
module c499_key_loader #(
    parameter int KEY_W = 24,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    c499_key_loader_if.slave   key_if,
    input  logic               relock,
    output logic [KEY_W-1:0]   key_out,
    output logic               key_locked,
    output logic               commit_ok,
    output logic               commit_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_LOCKED,
        ST_ERROR
    } state_e;

    localparam logic [CNT_W-1:0] KEY_BEATS   = CNT_W'(KEY_W);
    localparam logic [CNT_W-1:0] FRAME_BEATS = CNT_W'(KEY_W + 1);

    state_e             state_q,      state_d;
    logic [KEY_W-1:0]   shadow_q,     shadow_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic               par_q,        par_d;
    logic               last_q,       last_d;
    logic [KEY_W-1:0]   key_out_q,    key_out_d;
    logic               key_locked_q, key_locked_d;
    logic               commit_ok_q,  commit_ok_d;
    logic               commit_err_q, commit_err_d;
    logic               key_ready_q,  key_ready_d;

    logic               accept;
    logic               frame_pass;

    assign accept     = key_if.key_valid && key_ready_q;
    // A frame passes only with exactly KEY_W+1 beats, key_last on the parity
    // beat, and an even running XOR over key and parity bits.
    assign frame_pass = (cnt_q == FRAME_BEATS) && last_q && !par_q;

    // Next-state and next-output computation for the load FSM.
    always_comb begin
        // NOTE: every variable gets a default here so no latch is inferred.
        state_d      = state_q;
        shadow_d     = shadow_q;
        cnt_d        = cnt_q;
        par_d        = par_q;
        last_d       = last_q;
        key_out_d    = key_out_q;
        key_locked_d = key_locked_q;
        commit_ok_d  = 1'b0;
        commit_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_SHIFT: begin
                if (accept) begin
                    // Key beats land at their bit position; the parity beat
                    // only contributes to the running XOR.
                    if (cnt_q < KEY_BEATS) begin
                        shadow_d = shadow_q | (KEY_W'(key_if.key_bit) << cnt_q);
                    end
                    par_d  = par_q ^ key_if.key_bit;
                    cnt_d  = cnt_q + 1'b1;
                    last_d = key_if.key_last;
                    // Early key_last ends the frame; so does the parity beat.
                    if (key_if.key_last || (cnt_q == KEY_BEATS)) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end

            ST_CHECK: begin
                if (frame_pass) begin
                    key_out_d    = shadow_q;
                    key_locked_d = 1'b1;
                    commit_ok_d  = 1'b1;
                    state_d      = ST_LOCKED;
                end else begin
                    commit_err_d = 1'b1;
                    shadow_d     = '0;
                    cnt_d        = '0;
                    par_d        = 1'b0;
                    last_d       = 1'b0;
                    state_d      = ST_ERROR;
                end
            end

            ST_LOCKED: begin
                state_d = ST_LOCKED;
            end

            ST_ERROR: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Relock wins over everything, including a pending commit or error.
        if (relock) begin
            state_d      = ST_IDLE;
            shadow_d     = '0;
            cnt_d        = '0;
            par_d        = 1'b0;
            last_d       = 1'b0;
            key_out_d    = '0;
            key_locked_d = 1'b0;
            commit_ok_d  = 1'b0;
            commit_err_d = 1'b0;
        end

        // Ready is registered from the next state, so it never depends
        // combinationally on key_valid.
        key_ready_d = (state_d == ST_IDLE) || (state_d == ST_SHIFT);
    end

    // State and registered outputs; asynchronous reset aborts any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shadow_q     <= '0;
            cnt_q        <= '0;
            par_q        <= 1'b0;
            last_q       <= 1'b0;
            key_out_q    <= '0;
            key_locked_q <= 1'b0;
            commit_ok_q  <= 1'b0;
            commit_err_q <= 1'b0;
            key_ready_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so all flops update together.
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            cnt_q        <= cnt_d;
            par_q        <= par_d;
            last_q       <= last_d;
            key_out_q    <= key_out_d;
            key_locked_q <= key_locked_d;
            commit_ok_q  <= commit_ok_d;
            commit_err_q <= commit_err_d;
            key_ready_q  <= key_ready_d;
        end
    end

    assign key_if.key_ready = key_ready_q;
    assign key_out          = key_out_q;
    assign key_locked       = key_locked_q;
    assign commit_ok        = commit_ok_q;
    assign commit_err       = commit_err_q;

endmodule

// File: tb/tb_c499_key_loader.sv
// Randomized self-checking bench for c499_key_loader against a frame-level
// reference model (expected outcome derived from frame length, key_last
// position and parity of the whole frame).
module tb_c499_key_loader;

    localparam int KEY_W = 24;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             relock = 1'b0;
    logic [KEY_W-1:0] key_out;
    logic             key_locked;
    logic             commit_ok;
    logic             commit_err;

    c499_key_loader_if kif();

    c499_key_loader #(.KEY_W(KEY_W), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_if     (kif),
        .relock     (relock),
        .key_out    (key_out),
        .key_locked (key_locked),
        .commit_ok  (commit_ok),
        .commit_err (commit_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: what the downstream core should currently see.
    logic [KEY_W-1:0] m_key = '0;
    bit               m_locked = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_key_out"}, 32'(key_out), 32'h0);
        check({tag, "_locked"},  32'(key_locked), 32'h0);
        check({tag, "_ready"},   32'(kif.key_ready), 32'h1);
        check({tag, "_ok"},      32'(commit_ok), 32'h0);
        check({tag, "_err"},     32'(commit_err), 32'h0);
    endtask

    // Drives nbeats beats (key bits LSB first, then parity); key_last on beat
    // number last_pos (1-based, 0 = never). Returns at the negedge right after
    // the edge that took the final beat.
    task automatic drive_frame(input logic [KEY_W-1:0] key, input logic par,
                               input int nbeats, input int last_pos, input bit gaps);
        int b = 0;
        while (b < nbeats) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                kif.key_valid = 1'b0;
                kif.key_bit   = 1'($urandom);
                kif.key_last  = 1'($urandom);
            end else begin
                check("ready_beat", 32'(kif.key_ready), 32'(!m_locked));
                if (m_locked) begin
                    check("locked_key_hold", 32'(key_out), 32'(m_key));
                    check("locked_no_ok", 32'(commit_ok), 32'h0);
                end
                kif.key_valid = 1'b1;
                kif.key_bit   = (b < KEY_W) ? key[b] : par;
                kif.key_last  = ((b + 1) == last_pos);
                b++;
            end
        end
        @(negedge clk);
        kif.key_valid = 1'b0;
        kif.key_last  = 1'b0;
        kif.key_bit   = 1'b0;
    endtask

    // Checks the two cycles after a frame against the model's verdict.
    task automatic expect_outcome(input logic [KEY_W-1:0] key, input logic par, input int last_pos);
        bit pass;
        if (m_locked) begin
            for (int i = 0; i < 2; i++) begin
                check("ign_ready",  32'(kif.key_ready), 32'h0);
                check("ign_ok",     32'(commit_ok), 32'h0);
                check("ign_err",    32'(commit_err), 32'h0);
                check("ign_key",    32'(key_out), 32'(m_key));
                @(negedge clk);
            end
            return;
        end
        pass = (last_pos == KEY_W + 1) && (((^key) ^ par) == 1'b0);
        check("check_ready_low", 32'(kif.key_ready), 32'h0);
        check("check_no_pulse",  32'({commit_ok, commit_err}), 32'h0);
        @(negedge clk);
        if (pass) begin
            m_key    = key;
            m_locked = 1'b1;
        end
        check("commit_ok",   32'(commit_ok), 32'(pass));
        check("commit_err",  32'(commit_err), 32'(!pass));
        check("key_locked",  32'(key_locked), 32'(m_locked));
        check("key_out",     32'(key_out), 32'(m_key));
        check("ready_t1",    32'(kif.key_ready), 32'h0);
        @(negedge clk);
        check("pulse_gone",  32'({commit_ok, commit_err}), 32'h0);
        check("ready_t2",    32'(kif.key_ready), 32'(!m_locked));
        check("key_out_t2",  32'(key_out), 32'(m_key));
    endtask

    task automatic do_relock();
        @(negedge clk);
        relock = 1'b1;
        @(negedge clk);
        relock   = 1'b0;
        m_key    = '0;
        m_locked = 1'b0;
        check("relock_key_out", 32'(key_out), 32'h0);
        check("relock_locked",  32'(key_locked), 32'h0);
        check("relock_ready",   32'(kif.key_ready), 32'h1);
        check("relock_pulse",   32'({commit_ok, commit_err}), 32'h0);
    endtask

    task automatic frame(input logic [KEY_W-1:0] key, input logic par, input int last_pos, input bit gaps);
        int nbeats;
        nbeats = (last_pos == 0) ? KEY_W + 1 : last_pos;
        drive_frame(key, par, nbeats, last_pos, gaps);
        expect_outcome(key, par, last_pos);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [KEY_W-1:0] rk;
        logic             rp;
        int               lp;
        int               r;

        kif.key_valid = 1'b0;
        kif.key_bit   = 1'b0;
        kif.key_last  = 1'b0;

        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Good frame, continuous valid.
        frame(24'hA5C3F0, 1'b0, 25, 1'b0);
        // Locked: a new frame is ignored.
        frame(24'h000001, 1'b1, 25, 1'b0);
        do_relock();

        // Bad parity, then a correct frame.
        frame(24'hA5C3F0, 1'b1, 25, 1'b0);
        frame(24'hA5C3F0, 1'b0, 25, 1'b0);
        do_relock();

        // Length errors: early key_last, and missing key_last.
        frame(24'h5A5A5A, 1'b0, 10, 1'b0);
        frame(24'h5A5A5A, 1'b0, 0, 1'b0);

        // Odd-weight key with parity 1.
        frame(24'h123456, 1'b1, 25, 1'b0);
        do_relock();

        // Relock on the CHECK cycle suppresses the commit.
        drive_frame(24'hA5C3F0, 1'b0, 25, 25, 1'b0);
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        check("rl_chk_pulse",  32'({commit_ok, commit_err}), 32'h0);
        check("rl_chk_locked", 32'(key_locked), 32'h0);
        check("rl_chk_key",    32'(key_out), 32'h0);
        check("rl_chk_ready",  32'(kif.key_ready), 32'h1);
        @(negedge clk);
        check("rl_chk_pulse2", 32'({commit_ok, commit_err}), 32'h0);

        // Asynchronous reset between edges after beat 12.
        drive_frame(24'hFFFFFF, 1'b0, 12, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midframe_rst");
        @(negedge clk);
        rst_n = 1'b1;
        frame(24'hA5C3F0, 1'b0, 25, 1'b0);

        // Asynchronous reset while locked clears key_out immediately.
        #2 rst_n = 1'b0;
        #1 check_reset_values("locked_rst");
        m_key    = '0;
        m_locked = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized frames with random valid gaps.
        for (int n = 0; n < 40; n++) begin
            if (m_locked && $urandom_range(0, 1) == 0) begin
                do_relock();
            end else begin
                rk = KEY_W'($urandom);
                r  = int'($urandom_range(0, 9));
                if (r < 6)      lp = 25;
                else if (r < 8) lp = int'($urandom_range(2, 24));
                else            lp = 0;
                rp = (^rk) ^ ($urandom_range(0, 3) == 0);
                frame(rk, rp, lp, 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
